// File: rtl/alu_seq.sv
// alu_seq: single-cycle ALU with valid/ready handshake; defining ALU_SEQ_MUL_EN adds a
// multi-cycle radix-2 shift-add multiplier, otherwise MUL returns zero in one cycle.
module alu_seq #(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             zero,
  output logic             busy
);
  logic accept, load, idle, ld_c, alu_c;
  logic [WIDTH-1:0] alu_r, ld_r, ld_hi;
  logic [SHAMT_W-1:0] shamt;
  logic out_valid_q, out_valid_d, carry_q, carry_d, zero_q, zero_d;
  logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
  assign shamt = operand2[SHAMT_W-1:0];
  always_comb begin
    alu_c = 1'b0;
    alu_r = '0;
    case (opcode)
      4'd0:         {alu_c, alu_r} = {1'b0, operand1} + {1'b0, operand2};
      4'd1:         {alu_c, alu_r} = {1'b0, operand1} - {1'b0, operand2};
      4'd3:         {alu_c, alu_r} = {1'b0, operand1} + (WIDTH+1)'(1);
      4'd4:         {alu_c, alu_r} = {1'b0, operand1} - (WIDTH+1)'(1);
      4'd5:         alu_r = operand1 & operand2;
      4'd6:         alu_r = operand1 | operand2;
      4'd7:         alu_r = ~operand1;
      4'd8:         alu_r = ~(operand1 & operand2);
      4'd9:         alu_r = ~(operand1 | operand2);
      4'd10:        alu_r = operand1 ^ operand2;
      4'd11:        alu_r = ~(operand1 ^ operand2);
      4'd12:        alu_r = $signed(operand1) >>> shamt;
      4'd13, 4'd15: alu_r = operand1 << shamt;
      4'd14:        alu_r = operand1 >> shamt;
      default:      alu_r = '0;
    endcase
  end
`ifdef ALU_SEQ_MUL_EN
  typedef enum logic {IDLE, MULT} state_t;
  state_t state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d, prod_step;
  logic [WIDTH:0] psum;
  logic mul_start, mul_done;
  assign mul_start = accept && opcode == 4'd2;
  assign busy = state_q == MULT;
  assign idle = state_q == IDLE;
  assign mul_done = busy && cnt_q == SHAMT_W'(WIDTH - 1);
  // multiplier sits in the low half and retires one bit per step as the sum shifts in on top
  assign psum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q & {WIDTH{prod_q[0]}}};
  assign prod_step = {psum, prod_q[WIDTH-1:1]};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    mcand_d = mcand_q;
    prod_d = prod_q;
    if (mul_start) begin
      state_d = MULT;
      cnt_d = '0;
      mcand_d = operand1;
      prod_d = {{WIDTH{1'b0}}, operand2};
    end else if (busy) begin
      prod_d = prod_step;
      cnt_d = mul_done ? '0 : cnt_q + SHAMT_W'(1);
      state_d = mul_done ? IDLE : MULT;
    end
  end
  assign load = (accept && !mul_start) || mul_done;
  assign ld_r = mul_done ? prod_step[WIDTH-1:0] : alu_r;
  assign ld_hi = mul_done ? prod_step[2*WIDTH-1:WIDTH] : '0;
  assign ld_c = !mul_done && alu_c;
`else
  assign busy = 1'b0;
  assign idle = 1'b1;
  assign load = accept;
  assign ld_r = alu_r;
  assign ld_hi = '0;
  assign ld_c = alu_c;
`endif
  assign in_ready = rst_n && idle && (!out_valid_q || out_ready);
  assign accept = in_valid && in_ready;
  always_comb begin
    out_valid_d = load || (out_valid_q && !out_ready);
    result_d = load ? ld_r : result_q;
    result_hi_d = load ? ld_hi : result_hi_q;
    carry_d = load ? ld_c : carry_q;
    zero_d = load ? ({ld_hi, ld_r} == '0) : zero_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q <= '0;
      result_hi_q <= '0;
      carry_q <= 1'b0;
      zero_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      state_q <= IDLE;
      cnt_q <= '0;
      mcand_q <= '0;
      prod_q <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      result_q <= result_d;
      result_hi_q <= result_hi_d;
      carry_q <= carry_d;
      zero_q <= zero_d;
`ifdef ALU_SEQ_MUL_EN
      state_q <= state_d;
      cnt_q <= cnt_d;
      mcand_q <= mcand_d;
      prod_q <= prod_d;
`endif
    end
  end
  assign out_valid = out_valid_q;
  assign result = result_q;
  assign result_hi = result_hi_q;
  assign carry_out = carry_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table vectors, handshake corner sequences and random opcode streams at
// WIDTH=32 and WIDTH=8, checked through a per-instance scoreboard queue.
module tb_alu_seq;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  typedef struct {
    logic [63:0] r;
    logic [63:0] hi;
    logic        c;
    int          acc;
    int          lat;
  } exp_t;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        c;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, ordy = 1'b1;
  logic iv32 = 1'b0, ir32, ov32, c32, z32, b32;
  logic [3:0] op32 = '0;
  logic [31:0] a32 = '0, bb32 = '0, r32, h32;
  logic iv8 = 1'b0, ir8, ov8, c8, z8, b8;
  logic [3:0] op8 = '0;
  logic [7:0] a8 = '0, bb8 = '0, r8, h8;
  int cyc = 0, n_chk = 0, n_fail = 0, rise_cyc = 0;
  logic pv32 = 1'b0, pv8 = 1'b0;
  exp_t q32[$], q8[$];
  vec_t vt[20];
  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .opcode(op32),
    .operand1(a32), .operand2(bb32), .out_valid(ov32), .out_ready(ordy), .result(r32),
    .result_hi(h32), .carry_out(c32), .zero(z32), .busy(b32)
  );
  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .opcode(op8),
    .operand1(a8), .operand2(bb8), .out_valid(ov8), .out_ready(ordy), .result(r8),
    .result_hi(h8), .carry_out(c8), .zero(z8), .busy(b8)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [3:0] op, input logic [63:0] a_in, input logic [63:0] b_in, input int w);
    exp_t e;
    logic [63:0] m, a, b, p;
    int sh;
    m = (64'd1 << w) - 64'd1;
    a = a_in & m;
    b = b_in & m;
    sh = int'(b % 64'(w));
    e.r = '0; e.hi = '0; e.c = 1'b0; e.acc = 0; e.lat = 1;
    case (op)
      4'd0: begin p = a + b; e.r = p & m; e.c = p[w]; end
      4'd1: begin e.r = (a - b) & m; e.c = a < b; end
      4'd2: begin
        p = a * b;
        e.r = MUL_EN ? p & m : '0;
        e.hi = MUL_EN ? p >> w : '0;
        e.lat = MUL_EN ? w + 1 : 1;
      end
      4'd3: begin e.r = (a + 1) & m; e.c = a == m; end
      4'd4: begin e.r = (a - 1) & m; e.c = a == 0; end
      4'd5: e.r = a & b;
      4'd6: e.r = a | b;
      4'd7: e.r = ~a & m;
      4'd8: e.r = ~(a & b) & m;
      4'd9: e.r = ~(a | b) & m;
      4'd10: e.r = a ^ b;
      4'd11: e.r = ~(a ^ b) & m;
      4'd12: begin
        p = a;
        for (int i = 0; i < sh; i++) p = (p >> 1) | (p & (64'd1 << (w - 1)));
        e.r = p;
      end
      4'd14: e.r = a >> sh;
      default: e.r = (a << sh) & m;
    endcase
    return e;
  endfunction
  // caller is just after a rising edge; returns just after the accepting edge
  task automatic send(input bit w8, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                      input exp_t e_in, output int acc);
    exp_t e;
    bit ok;
    ok = 1'b0;
    e = e_in;
    if (w8) begin iv8 = 1'b1; op8 = op; a8 = a[7:0]; bb8 = b[7:0]; end
    else begin iv32 = 1'b1; op32 = op; a32 = a[31:0]; bb32 = b[31:0]; end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (w8 ? ir8 : ir32) begin ok = 1'b1; break; end
    end
    chk("accept_wait", 64'(ok), 64'd1);
    acc = cyc;
    e.acc = cyc;
    @(posedge clk);
    if (w8) q8.push_back(e); else q32.push_back(e);
    #1;
    if (w8) iv8 = 1'b0; else iv32 = 1'b0;
  endtask
  task automatic cmp(input string tag, input exp_t e, input logic [63:0] r, input logic [63:0] h,
                     input logic c, input logic z);
    chk({tag, "_result"}, r, e.r);
    chk({tag, "_result_hi"}, h, e.hi);
    chk({tag, "_carry"}, 64'(c), 64'(e.c));
    chk({tag, "_zero"}, 64'(z), 64'(e.r == 0 && e.hi == 0));
    chk({tag, "_latency"}, 64'(cyc - e.acc), 64'(e.lat));
  endtask
  always @(negedge clk) begin
    if (rst_n && ov32 && !pv32) begin
      if (q32.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL w32_spurious: got out_valid=1, expected 0 with nothing pending");
      end else cmp("w32", q32[0], r32, h32, c32, z32);
    end
    if (rst_n && ov32 && ordy && q32.size() > 0) void'(q32.pop_front());
    pv32 <= rst_n && ov32 && !ordy;
    if (rst_n && ov8 && !pv8) begin
      if (q8.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL w8_spurious: got out_valid=1, expected 0 with nothing pending");
      end else cmp("w8", q8[0], r8, h8, c8, z8);
    end
    if (rst_n && ov8 && ordy && q8.size() > 0) void'(q8.pop_front());
    pv8 <= rst_n && ov8 && !ordy;
  end
  initial begin
    exp_t e;
    int acc, prev_acc;
    logic [3:0] prev_op;
    logic seen;
    logic [63:0] ra, rb;
    vt[0]  = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    vt[1]  = '{4'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b1};
    vt[2]  = '{4'd12, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0};
    vt[3]  = '{4'd14, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0};
    vt[4]  = '{4'd0,  32'h12345678, 32'h11111111, 32'h23456789, 1'b0};
    vt[5]  = '{4'd1,  32'h00000007, 32'h00000005, 32'h00000002, 1'b0};
    vt[6]  = '{4'd3,  32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1};
    vt[7]  = '{4'd3,  32'h00000041, 32'h00000000, 32'h00000042, 1'b0};
    vt[8]  = '{4'd4,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1};
    vt[9]  = '{4'd4,  32'h00000010, 32'h00000000, 32'h0000000F, 1'b0};
    vt[10] = '{4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    vt[11] = '{4'd6,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0};
    vt[12] = '{4'd7,  32'hF0F0F0F0, 32'h00012345, 32'h0F0F0F0F, 1'b0};
    vt[13] = '{4'd8,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 1'b0};
    vt[14] = '{4'd9,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0};
    vt[15] = '{4'd10, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
    vt[16] = '{4'd11, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF00FF00F, 1'b0};
    vt[17] = '{4'd13, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0};
    vt[18] = '{4'd15, 32'h00000003, 32'h00000024, 32'h00000030, 1'b0};
    vt[19] = '{4'd12, 32'h7FFFFFFF, 32'h00000008, 32'h007FFFFF, 1'b0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(ir32), 64'd0);
    chk("rst_out_valid", 64'(ov32), 64'd0);
    chk("rst_result", 64'(r32), 64'd0);
    chk("rst_result_hi", 64'(h32), 64'd0);
    chk("rst_carry", 64'(c32), 64'd0);
    chk("rst_zero", 64'(z32), 64'd0);
    chk("rst_busy", 64'(b32), 64'd0);
    chk("rst_busy8", 64'(b8), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(ir32), 64'd1);
    chk("release_in_ready8", 64'(ir8), 64'd1);
    @(posedge clk);
    #1;
    foreach (vt[i]) begin
      e = '{r: 64'(vt[i].r), hi: 64'd0, c: vt[i].c, acc: 0, lat: 1};
      send(1'b0, vt[i].op, 64'(vt[i].a), 64'(vt[i].b), e, acc);
    end
    // back-pressure: result must freeze while a new request waits for the slot
    e = '{r: 64'd0, hi: 64'd0, c: 1'b1, acc: 0, lat: 1};
    send(1'b0, 4'd0, 64'hFFFFFFFF, 64'd1, e, acc);
    ordy = 1'b0;
    fork
      begin
        e = '{r: 64'd5, hi: 64'd0, c: 1'b0, acc: 0, lat: 1};
        send(1'b0, 4'd1, 64'd9, 64'd4, e, acc);
      end
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("hold_valid", 64'(ov32), 64'd1);
          chk("hold_result", 64'(r32), 64'd0);
          chk("hold_carry", 64'(c32), 64'd1);
          chk("hold_zero", 64'(z32), 64'd1);
          chk("hold_in_ready", 64'(ir32), 64'd0);
        end
        @(posedge clk);
        #1 ordy = 1'b1;
        @(negedge clk);
        rise_cyc = cyc;
        chk("resume_in_ready", 64'(ir32), 64'd1);
      end
    join
    chk("accept_on_resume", 64'(acc), 64'(rise_cyc));
`ifdef ALU_SEQ_MUL_EN
    e = '{r: 64'h00000001, hi: 64'hFFFFFFFE, c: 1'b0, acc: 0, lat: 33};
    send(1'b0, 4'd2, 64'hFFFFFFFF, 64'hFFFFFFFF, e, acc);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("mul_in_ready", 64'(ir32), 64'd0);
      chk("mul_busy", 64'(b32), 64'd1);
    end
    @(negedge clk);
    chk("mul_done_valid", 64'(ov32), 64'd1);
    chk("mul_done_busy", 64'(b32), 64'd0);
    @(posedge clk);
    #1;
    e = model(4'd2, 64'h12345, 64'h6789, 32);
    send(1'b0, 4'd2, 64'h12345, 64'h6789, e, acc);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midmul_rst_in_ready", 64'(ir32), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    q32.delete();
    @(negedge clk);
    chk("midmul_busy", 64'(b32), 64'd0);
    chk("midmul_out_valid", 64'(ov32), 64'd0);
    chk("midmul_in_ready", 64'(ir32), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | ov32;
    end
    chk("midmul_abandoned", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
`endif
    for (int w = 0; w < 2; w++) begin
      prev_acc = -1;
      prev_op = 4'd0;
      for (int o = 0; o < 16; o++) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        e = model(4'(o), ra, rb, w == 1 ? 8 : 32);
        send(w == 1, 4'(o), ra, rb, e, acc);
        if (prev_acc >= 0)
          chk(w == 1 ? "stream8_throughput" : "stream32_throughput", 64'(acc - prev_acc),
              64'((prev_op == 4'd2 && MUL_EN) ? (w == 1 ? 9 : 33) : 1));
        prev_acc = acc;
        prev_op = 4'(o);
      end
    end
    repeat (3) @(negedge clk);
    chk("drain32", 64'(q32.size()), 64'd0);
    chk("drain8", 64'(q8.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
